count_sequence_checker: RTL and testbench
=========================================

Name: count_sequence_checker

Overview:
- Receive-side companion to the enable-gated free-running counter.
- Samples the counter's enable and count value every clock and checks each step against the counter's rule: +1 modulo 2^WIDTH when enabled, hold when disabled.
- Reports lock status, mismatch events, a saturating error tally and a wrap tally.
- Sits alongside the counter in the lab top level and in self-checking benches. The FPGA build routes its status outputs to LEDs.

Parameters:
WIDTH, 4, width of the monitored count bus
LOCK_LEN, 2, consecutive matching checks required before locked asserts (1..15)
ERR_CNT_W, 8, width of err_count (saturating)
WRAP_CNT_W, 8, width of wrap_count (saturating)

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-low reset, shared with the monitored counter
enable  input  1  same enable signal that drives the counter
cnt  input  WIDTH  registered count output of the monitored counter
clear  input  1  synchronous clear of err_sticky, err_count and wrap_count
locked  output  1  high while LOCK_LEN or more consecutive checks have matched
err_pulse  output  1  one-cycle strobe on each mismatch
err_sticky  output  1  set on first mismatch; held until clear or reset
err_count  output  ERR_CNT_W  number of mismatches, saturates at all-ones
wrap_count  output  WRAP_CNT_W  number of verified max-to-0 wraps, saturates at all-ones
exp_cnt  output  WIDTH  predicted value for the next sample

Behaviour:
- Reset: reset is synchronous and active-low (reset==0 at a rising clk edge). At reset, every output is 0 and internal state goes to SYNC with no baseline. Reset overrides clear and any check.
- Sample definitions: sample n is (cnt_n, en_n) captured at edge n. Prediction is exp = en_n ? (cnt_n + 1) mod 2^WIDTH : cnt_n. The +1 is computed in WIDTH bits so it truncates naturally.
- State SYNC:
  - Capture the current sample as the baseline.
  - No check, no error.
  - lock_run = 0, locked = 0.
  - Next state: TRACK.
- State TRACK: on each edge, compare cnt_{n+1} with exp.
  - Match: lock_run increments, saturating at LOCK_LEN. locked = 1 once lock_run reaches LOCK_LEN.
  - Mismatch:
    - err_pulse = 1 for exactly the following cycle.
    - err_sticky = 1.
    - err_count saturating +1.
    - locked = 0, lock_run = 0.
    - The mismatching sample becomes the new baseline (resync in place; no dead cycle). The next edge is checked against it.
- Latency: outputs are registered. The result of the check at edge n+1 is visible after edge n+1.
- exp_cnt always shows the prediction derived from the latest baseline. It is 0 after reset.
- Wrap: a matching check with en_n = 1, cnt_n = all-ones and cnt_{n+1} = 0 increments wrap_count (saturating). A mismatch never counts as a wrap.
- enable low: the hold is checked. A changed cnt while enable was low is a mismatch.
- clear:
  - Same edge zeroes err_sticky, err_count and wrap_count.
  - Has priority over a simultaneous mismatch or wrap increment: the tallies become 0, not 1.
  - err_pulse and the lock/resync logic still react to that mismatch.
  - Does not affect locked, lock_run, exp_cnt or the baseline.
- Reset mid-operation: all tallies are lost. The first sample after reset rises is baseline only; the counter is expected at 0 but this is not checked.
- Saturation: at all-ones, err_count and wrap_count hold. Further events still pulse err_pulse and set err_sticky.

Test Plan:
1. reset=0 for 2 edges, then reset=1, enable=1, ideal counter model -> no err_pulse. locked=1 at the 3rd edge after release (baseline + 2 matches). After cnt passes 15 -> 0, wrap_count=1. err_count=0 throughout.
2. Locked, then enable=0 for 20 cycles with cnt holding at 9 -> locked stays 1, exp_cnt=9, no errors. enable=1 -> next cnt 10 matches.
3. Expected cnt=4, force cnt=7 for one sample -> err_pulse high for 1 cycle, err_sticky=1, err_count=1, locked=0. Counter then continues from 7 (8, 9) -> locked=1 again after 2 matches, with no further errors.
4. ERR_CNT_W=2, inject 5 separate mismatches -> err_count=3 (saturated), 5 err_pulse strobes seen, err_sticky=1.
5. Build err_sticky=1 and wrap_count=3, then reset=0 for 1 edge -> all outputs 0. First post-reset sample is not checked even if cnt!=0.
6. Assert clear on the same edge as a mismatch -> err_pulse=1, err_sticky=0, err_count=0, locked=0. The next clean mismatch gives err_count=1.

Source files
------------

// File: rtl/count_sequence_checker.sv
// Receive-side checker for an enable-gated free-running counter.
// Verifies +1/hold steps, tracks lock, mismatches and verified wraps.
module count_sequence_checker #(
    parameter int WIDTH      = 4,
    parameter int LOCK_LEN   = 2,
    parameter int ERR_CNT_W  = 8,
    parameter int WRAP_CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [WIDTH-1:0]      cnt,
    input  logic                  clear,
    output logic                  locked,
    output logic                  err_pulse,
    output logic                  err_sticky,
    output logic [ERR_CNT_W-1:0]  err_count,
    output logic [WRAP_CNT_W-1:0] wrap_count,
    output logic [WIDTH-1:0]      exp_cnt
);

    localparam int LR_W = $clog2(LOCK_LEN + 1);
    localparam logic [LR_W-1:0] LOCK_MAX = LR_W'(LOCK_LEN);

    typedef enum logic {
        SYNC,
        TRACK
    } state_e;

    state_e                  state_q;
    logic [WIDTH-1:0]        exp_cnt_q;
    logic [WIDTH-1:0]        base_cnt_q;
    logic                    base_en_q;
    logic [LR_W-1:0]         lock_run_q;
    logic                    locked_q;
    logic                    err_pulse_q;
    logic                    err_sticky_q;
    logic [ERR_CNT_W-1:0]    err_count_q;
    logic [WRAP_CNT_W-1:0]   wrap_count_q;

    logic [WIDTH-1:0]        exp_cnt_d;
    logic [LR_W-1:0]         lock_run_d;
    logic [ERR_CNT_W-1:0]    err_count_d;
    logic [WRAP_CNT_W-1:0]   wrap_count_d;
    logic                    match;
    logic                    wrap_hit;

    always_comb begin
        exp_cnt_d    = enable ? cnt + WIDTH'(1) : cnt;
        match        = (cnt == exp_cnt_q);
        wrap_hit     = match && base_en_q && (&base_cnt_q) && (cnt == '0);
        lock_run_d   = (lock_run_q == LOCK_MAX) ? lock_run_q
                                                : lock_run_q + LR_W'(1);
        err_count_d  = (&err_count_q) ? err_count_q
                                      : err_count_q + ERR_CNT_W'(1);
        wrap_count_d = (&wrap_count_q) ? wrap_count_q
                                       : wrap_count_q + WRAP_CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= SYNC;
            exp_cnt_q    <= '0;
            base_cnt_q   <= '0;
            base_en_q    <= 1'b0;
            lock_run_q   <= '0;
            locked_q     <= 1'b0;
            err_pulse_q  <= 1'b0;
            err_sticky_q <= 1'b0;
            err_count_q  <= '0;
            wrap_count_q <= '0;
        end else begin
            // Every sample, matching or not, becomes the next baseline.
            state_q    <= TRACK;
            exp_cnt_q  <= exp_cnt_d;
            base_cnt_q <= cnt;
            base_en_q  <= enable;
            unique case (state_q)
                SYNC: begin
                    lock_run_q  <= '0;
                    locked_q    <= 1'b0;
                    err_pulse_q <= 1'b0;
                end
                TRACK: begin
                    if (match) begin
                        lock_run_q  <= lock_run_d;
                        locked_q    <= (lock_run_d == LOCK_MAX);
                        err_pulse_q <= 1'b0;
                        if (wrap_hit) begin
                            wrap_count_q <= wrap_count_d;
                        end
                    end else begin
                        lock_run_q   <= '0;
                        locked_q     <= 1'b0;
                        err_pulse_q  <= 1'b1;
                        err_sticky_q <= 1'b1;
                        err_count_q  <= err_count_d;
                    end
                end
                default: state_q <= SYNC;
            endcase
            // Clear wins over a same-edge increment.
            if (clear) begin
                err_sticky_q <= 1'b0;
                err_count_q  <= '0;
                wrap_count_q <= '0;
            end
        end
    end

    assign locked     = locked_q;
    assign err_pulse  = err_pulse_q;
    assign err_sticky = err_sticky_q;
    assign err_count  = err_count_q;
    assign wrap_count = wrap_count_q;
    assign exp_cnt    = exp_cnt_q;

endmodule

// File: tb/tb_count_sequence_checker.sv
// Randomized and directed bench for count_sequence_checker.
// Small narrow tallies so saturation is reachable quickly.
module tb_count_sequence_checker;

    localparam int W    = 4;
    localparam int LL   = 2;
    localparam int EW   = 2;
    localparam int WW   = 3;
    localparam int MOD  = 1 << W;
    localparam int EMAX = (1 << EW) - 1;
    localparam int WMAX = (1 << WW) - 1;
    localparam int VW   = 3 + EW + WW + W;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic          clr;
    logic [W-1:0]  cnt;
    logic          locked;
    logic          err_pulse;
    logic          err_sticky;
    logic [EW-1:0] err_count;
    logic [WW-1:0] wrap_count;
    logic [W-1:0]  exp_cnt;

    always #5 clk = ~clk;

    count_sequence_checker #(
        .WIDTH(W), .LOCK_LEN(LL), .ERR_CNT_W(EW), .WRAP_CNT_W(WW)
    ) dut (
        .clk(clk), .reset(rst_n), .enable(en), .cnt(cnt),
        .clear(clr), .locked(locked), .err_pulse(err_pulse),
        .err_sticky(err_sticky), .err_count(err_count),
        .wrap_count(wrap_count), .exp_cnt(exp_cnt)
    );

    int vecs = 0;
    int bad  = 0;
    int ctr  = 0;

    // Reference state: previous sample plus run length and tallies.
    bit m_have, m_pe, m_locked, m_pulse, m_sticky;
    int m_pc, m_run, m_errs, m_wraps, m_exp;
    logic [VW-1:0] m_vec = '0;
    logic [VW-1:0] act_v;

    assign act_v = {locked, err_pulse, err_sticky,
                    err_count, wrap_count, exp_cnt};

    function automatic int pred(int c, bit e);
        return e ? (c + 1) % MOD : c;
    endfunction

    task automatic drive(int c, bit e, bit cl, bit r);
        bit ok;
        @(negedge clk);
        cnt = W'(c); en = e; clr = cl; rst_n = r;
        @(posedge clk);
        if (!r) begin
            m_have = 0; m_run = 0; m_locked = 0; m_pulse = 0;
            m_sticky = 0; m_errs = 0; m_wraps = 0; m_exp = 0;
        end else begin
            if (m_have) begin
                ok = (c == pred(m_pc, m_pe));
                if (ok) begin
                    m_run++;
                    m_pulse = 0;
                    if (m_pe && m_pc == MOD - 1 && c == 0)
                        m_wraps = (m_wraps < WMAX) ? m_wraps + 1 : WMAX;
                end else begin
                    m_run = 0;
                    m_pulse = 1;
                    m_sticky = 1;
                    m_errs = (m_errs < EMAX) ? m_errs + 1 : EMAX;
                end
            end else begin
                m_run = 0;
                m_pulse = 0;
            end
            if (cl) begin
                m_sticky = 0; m_errs = 0; m_wraps = 0;
            end
            m_locked = m_have && (m_run >= LL);
            m_have = 1; m_pc = c; m_pe = e; m_exp = pred(c, e);
        end
        m_vec = {m_locked, m_pulse, m_sticky, EW'(m_errs),
                 WW'(m_wraps), W'(m_exp)};
        #1;
    endtask

    task automatic cstep(bit e, bit cl);
        drive(ctr, e, cl, 1'b1);
        ctr = pred(ctr, e);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            drive(3, 1'b1, 1'b1, 1'b0);
            vecs++;
            if (act_v !== '0 || m_vec !== '0) begin
                bad++;
                $display("FAIL reset: got %h want 0", act_v);
            end
        end
    endtask

    task automatic test_count_wrap();
        ctr = 0;
        for (int i = 0; i < 40; i++) begin
            cstep(1'b1, 1'b0);
            vecs++;
            if (act_v !== m_vec) begin
                bad++;
                $display("FAIL count_wrap[%0d]: got %h want %h", i, act_v, m_vec);
            end
            if (i == 1 || i == 2) begin
                vecs++;
                if (locked !== (i == 2)) begin
                    bad++;
                    $display("FAIL lock_edge[%0d]: got %b want %b", i, locked, i == 2);
                end
            end
        end
        vecs++;
        if (wrap_count !== WW'(2) || err_count !== '0) begin
            bad++;
            $display("FAIL wrap_tally: got w=%0d e=%0d want w=2 e=0", wrap_count, err_count);
        end
    endtask

    task automatic test_hold();
        while (ctr != 9) begin
            cstep(1'b1, 1'b0);
            vecs++;
            if (act_v !== m_vec) begin
                bad++;
                $display("FAIL hold_pre: got %h want %h", act_v, m_vec);
            end
        end
        for (int i = 0; i < 20; i++) begin
            cstep(1'b0, 1'b0);
            vecs++;
            if (act_v !== m_vec) begin
                bad++;
                $display("FAIL hold[%0d]: got %h want %h", i, act_v, m_vec);
            end
        end
        vecs++;
        if (exp_cnt !== W'(9) || locked !== 1'b1 || err_pulse !== 1'b0) begin
            bad++;
            $display("FAIL hold_state: got exp=%0d lk=%b want exp=9 lk=1", exp_cnt, locked);
        end
        cstep(1'b1, 1'b0);
        cstep(1'b1, 1'b0);
        vecs++;
        if (err_pulse !== 1'b0 || locked !== 1'b1 || exp_cnt !== W'(11)) begin
            bad++;
            $display("FAIL hold_resume: got %h want %h", act_v, m_vec);
        end
    endtask

    task automatic test_mismatch();
        while (ctr != 3) cstep(1'b1, 1'b0);
        cstep(1'b1, 1'b0);
        ctr = 7;
        cstep(1'b1, 1'b0);
        vecs++;
        if (err_pulse !== 1'b1 || err_sticky !== 1'b1 ||
            err_count !== EW'(1) || locked !== 1'b0 || act_v !== m_vec) begin
            bad++;
            $display("FAIL mismatch: got %h want %h", act_v, m_vec);
        end
        cstep(1'b1, 1'b0);
        vecs++;
        if (err_pulse !== 1'b0 || locked !== 1'b0) begin
            bad++;
            $display("FAIL relock1: got %h want %h", act_v, m_vec);
        end
        cstep(1'b1, 1'b0);
        vecs++;
        if (locked !== 1'b1 || err_count !== EW'(1) || act_v !== m_vec) begin
            bad++;
            $display("FAIL relock2: got %h want %h", act_v, m_vec);
        end
    endtask

    task automatic test_saturation();
        int pulses = 0;
        for (int k = 0; k < 5; k++) begin
            cstep(1'b1, 1'b0);
            pulses += int'(err_pulse);
            cstep(1'b1, 1'b0);
            pulses += int'(err_pulse);
            ctr = (ctr + 5) % MOD;
            cstep(1'b1, 1'b0);
            pulses += int'(err_pulse);
            vecs++;
            if (act_v !== m_vec) begin
                bad++;
                $display("FAIL err_sat[%0d]: got %h want %h", k, act_v, m_vec);
            end
        end
        vecs++;
        if (pulses != 5 || err_count !== EW'(EMAX) || err_sticky !== 1'b1) begin
            bad++;
            $display("FAIL err_sat_tally: got p=%0d e=%0d want p=5 e=%0d", pulses, err_count, EMAX);
        end
        for (int i = 0; i < 8 * MOD + 2; i++) begin
            cstep(1'b1, 1'b0);
            vecs++;
            if (act_v !== m_vec) begin
                bad++;
                $display("FAIL wrap_sat[%0d]: got %h want %h", i, act_v, m_vec);
            end
        end
        vecs++;
        if (wrap_count !== WW'(WMAX)) begin
            bad++;
            $display("FAIL wrap_sat_tally: got %0d want %0d", wrap_count, WMAX);
        end
    endtask

    task automatic test_reset_mid();
        drive(ctr, 1'b1, 1'b0, 1'b0);
        vecs++;
        if (act_v !== '0) begin
            bad++;
            $display("FAIL reset_mid: got %h want 0", act_v);
        end
        ctr = 5;
        cstep(1'b1, 1'b0);
        vecs++;
        if (err_pulse !== 1'b0 || exp_cnt !== W'(6) || act_v !== m_vec) begin
            bad++;
            $display("FAIL post_reset_base: got %h want %h", act_v, m_vec);
        end
        cstep(1'b1, 1'b0);
        vecs++;
        if (err_pulse !== 1'b0 || err_count !== '0 || act_v !== m_vec) begin
            bad++;
            $display("FAIL post_reset_match: got %h want %h", act_v, m_vec);
        end
    endtask

    task automatic test_clear();
        ctr = (ctr + 2) % MOD;
        cstep(1'b1, 1'b0);
        cstep(1'b1, 1'b0);
        ctr = (ctr + 3) % MOD;
        cstep(1'b1, 1'b1);
        vecs++;
        if (err_pulse !== 1'b1 || err_sticky !== 1'b0 ||
            err_count !== '0 || locked !== 1'b0 || act_v !== m_vec) begin
            bad++;
            $display("FAIL clear_mismatch: got %h want %h", act_v, m_vec);
        end
        cstep(1'b1, 1'b0);
        cstep(1'b1, 1'b0);
        ctr = (ctr + 3) % MOD;
        cstep(1'b1, 1'b0);
        vecs++;
        if (err_count !== EW'(1) || err_sticky !== 1'b1 || act_v !== m_vec) begin
            bad++;
            $display("FAIL clear_after: got %h want %h", act_v, m_vec);
        end
    endtask

    task automatic test_random();
        int  r;
        bit  e, cl, rs;
        for (int i = 0; i < 800; i++) begin
            r  = int'($urandom_range(0, 99));
            rs = (r >= 2);
            if (r >= 2 && r < 10) ctr = int'($urandom_range(0, MOD - 1));
            cl = ($urandom_range(0, 19) == 0);
            e  = ($urandom_range(0, 3) != 0);
            drive(ctr, e, cl, rs);
            ctr = rs ? pred(ctr, e) : 0;
            vecs++;
            if (act_v !== m_vec) begin
                bad++;
                $display("FAIL random[%0d]: got %h want %h", i, act_v, m_vec);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; clr = 1'b0; cnt = '0;
        test_reset();
        test_count_wrap();
        test_hold();
        test_mismatch();
        test_saturation();
        test_reset_mid();
        test_clear();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, bad);
        $finish;
    end

endmodule
